sgmii_link_monitor: RTL and testbench

Link-state supervisor for the SGMII Ethernet path. It reads the PCS/PMA `status_vector` and `an_interrupt` that the Ethernet wrapper drives its configuration from, then debounces link status and latches the negotiated speed and duplex. It drives `an_restart_config` and the speed-select outputs back toward the PCS/PMA. It also provides a link-change interrupt and saturating error counters for the CPU-side register block. The block lives in the 125 MHz `userclk2` domain, alongside the MAC.

---
 rtl/sgmii_pkg.sv | 29 ++
 rtl/sgmii_link_monitor_sat_counter.sv | 22 ++
 rtl/sgmii_link_monitor.sv | 172 +++++++++++++++++
 tb/tb_sgmii_link_monitor.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sgmii_pkg.sv
// Shared definitions for the SGMII link monitor: status bit positions,
// speed encodings and the link FSM state type.
package sgmii_pkg;

    localparam int STAT_LINK         = 0;
    localparam int STAT_SYNC         = 1;
    localparam int STAT_RXDISPERR    = 5;
    localparam int STAT_RXNOTINTABLE = 6;
    localparam int STAT_PHY_LINK     = 7;
    localparam int STAT_SPEED_LSB    = 10;
    localparam int STAT_SPEED_MSB    = 11;
    localparam int STAT_DUPLEX       = 12;

    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_1000 = 2'b10;

    typedef enum logic [1:0] {
        DOWN        = 2'd0,
        DEBOUNCE_UP = 2'd1,
        UP          = 2'd2,
        RESTART     = 2'd3
    } link_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sgmii_link_monitor_sat_counter.sv
// Saturating event counter: holds at all-ones, synchronous clear beats increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sgmii_link_monitor.sv
// SGMII link supervisor: debounces PCS/PMA link status, latches speed/duplex,
// requests autonegotiation restarts and keeps link/error statistics.
module sgmii_link_monitor
    import sgmii_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES        = 1250000,
    parameter int RESTART_TIMEOUT_CYCLES = 125000000,
    parameter int RESTART_PULSE_CYCLES   = 16,
    parameter int CNT_WIDTH              = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [15:0]          status_vector,
    input  logic                 an_interrupt,
    input  logic                 irq_ack,
    input  logic                 counters_clear,
    output logic                 link_up,
    output logic [1:0]           speed,
    output logic                 full_duplex,
    output logic                 speed_is_10_100,
    output logic                 speed_is_100,
    output logic                 an_restart_config,
    output logic                 link_change_irq,
    output logic [CNT_WIDTH-1:0] link_down_count,
    output logic [CNT_WIDTH-1:0] rx_error_count,
    output link_state_t          link_state
);

    localparam int TIMER_SPAN = max_int(max_int(DEBOUNCE_CYCLES, RESTART_TIMEOUT_CYCLES),
                                        RESTART_PULSE_CYCLES);
    localparam int TIMER_W    = (TIMER_SPAN > 1) ? $clog2(TIMER_SPAN) : 1;

    // The cycle in DOWN that first sees raw_link counts as the first debounce
    // cycle, so DEBOUNCE_UP itself only needs DEBOUNCE_CYCLES-1 more.
    localparam logic [TIMER_W-1:0] DEBOUNCE_LAST = TIMER_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST  = TIMER_W'(RESTART_TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] PULSE_LAST    = TIMER_W'(RESTART_PULSE_CYCLES - 1);

    logic [15:0]        status_q;
    logic               an_q;
    logic               an_q_d;
    logic               raw_link;
    logic               rx_error;
    logic [1:0]         speed_seen;
    link_state_t        state;
    link_state_t        state_next;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_next;
    logic               link_gained;
    logic               link_lost;
    logic               irq_set;
    logic               unused_status;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            status_q <= '0;
            an_q     <= 1'b0;
            an_q_d   <= 1'b0;
        end else begin
            status_q <= status_vector;
            an_q     <= an_interrupt;
            an_q_d   <= an_q;
        end
    end

    assign raw_link      = status_q[STAT_LINK] & status_q[STAT_SYNC] & status_q[STAT_PHY_LINK];
    assign rx_error      = status_q[STAT_RXDISPERR] | status_q[STAT_RXNOTINTABLE];
    assign speed_seen    = status_q[STAT_SPEED_MSB:STAT_SPEED_LSB];
    assign unused_status = ^{status_q[15:13], status_q[9:8], status_q[4:2]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= DOWN;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    always_comb begin
        state_next  = state;
        timer_next  = timer + 1'b1;
        link_gained = 1'b0;
        link_lost   = 1'b0;
        case (state)
            DOWN: begin
                if (raw_link) begin
                    state_next = DEBOUNCE_UP;
                end else if (timer == TIMEOUT_LAST) begin
                    state_next = RESTART;
                end
            end
            DEBOUNCE_UP: begin
                if (!raw_link) begin
                    state_next = DOWN;
                end else if (timer == DEBOUNCE_LAST) begin
                    state_next  = UP;
                    link_gained = 1'b1;
                end
            end
            UP: begin
                timer_next = '0;
                if (!raw_link) begin
                    state_next = DOWN;
                    link_lost  = 1'b1;
                end else if (speed_seen != speed) begin
                    // A renegotiated speed is treated as a fresh link that must re-debounce.
                    state_next = DEBOUNCE_UP;
                    link_lost  = 1'b1;
                end
            end
            RESTART: begin
                if (timer == PULSE_LAST) begin
                    state_next = DOWN;
                end
            end
            default: state_next = DOWN;
        endcase
        if (state_next != state) begin
            timer_next = '0;
        end
    end

    assign irq_set    = link_gained | link_lost | (an_q & ~an_q_d);
    assign link_state = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            link_up           <= 1'b0;
            speed             <= SPEED_1000;
            full_duplex       <= 1'b1;
            speed_is_10_100   <= 1'b0;
            speed_is_100      <= 1'b0;
            an_restart_config <= 1'b0;
            link_change_irq   <= 1'b0;
        end else begin
            if (link_gained) begin
                link_up     <= 1'b1;
                speed       <= speed_seen;
                full_duplex <= status_q[STAT_DUPLEX];
            end else if (link_lost) begin
                link_up <= 1'b0;
            end
            speed_is_10_100   <= (speed != SPEED_1000);
            speed_is_100      <= (speed == SPEED_100);
            an_restart_config <= (state_next == RESTART);
            if (irq_set) begin
                link_change_irq <= 1'b1;
            end else if (irq_ack) begin
                link_change_irq <= 1'b0;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_link_down_count (
        .clock (clock),
        .reset (reset),
        .clear (counters_clear),
        .inc   (link_lost),
        .count (link_down_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_rx_error_count (
        .clock (clock),
        .reset (reset),
        .clear (counters_clear),
        .inc   (rx_error),
        .count (rx_error_count)
    );

endmodule

// File: tb/tb_sgmii_link_monitor.sv
// Directed bench for sgmii_link_monitor; inputs change and outputs are sampled
// on the falling edge, so "after edge k" means k rising edges after a drive point.
module tb_sgmii_link_monitor;
    import sgmii_pkg::*;

    localparam int CW = 4;

    logic          clock;
    logic          reset;
    logic [15:0]   status_vector;
    logic          an_interrupt;
    logic          irq_ack;
    logic          counters_clear;
    logic          link_up;
    logic [1:0]    speed;
    logic          full_duplex;
    logic          speed_is_10_100;
    logic          speed_is_100;
    logic          an_restart_config;
    logic          link_change_irq;
    logic [CW-1:0] link_down_count;
    logic [CW-1:0] rx_error_count;
    link_state_t   link_state;

    int passed = 0;
    int total  = 0;

    sgmii_link_monitor #(
        .DEBOUNCE_CYCLES        (8),
        .RESTART_TIMEOUT_CYCLES (100),
        .RESTART_PULSE_CYCLES   (4),
        .CNT_WIDTH              (CW)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .status_vector     (status_vector),
        .an_interrupt      (an_interrupt),
        .irq_ack           (irq_ack),
        .counters_clear    (counters_clear),
        .link_up           (link_up),
        .speed             (speed),
        .full_duplex       (full_duplex),
        .speed_is_10_100   (speed_is_10_100),
        .speed_is_100      (speed_is_100),
        .an_restart_config (an_restart_config),
        .link_change_irq   (link_change_irq),
        .link_down_count   (link_down_count),
        .rx_error_count    (rx_error_count),
        .link_state        (link_state)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #4 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Driver helpers
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
    endtask

    // Scoreboard
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        reset          = 1'b0;
        status_vector  = 16'h0000;
        an_interrupt   = 1'b0;
        irq_ack        = 1'b0;
        counters_clear = 1'b0;
        tick(3);

        check("rst_link_up",   16'(link_up), 16'h0);
        check("rst_speed",     16'(speed), 16'h2);
        check("rst_duplex",    16'(full_duplex), 16'h1);
        check("rst_is_10_100", 16'(speed_is_10_100), 16'h0);
        check("rst_is_100",    16'(speed_is_100), 16'h0);
        check("rst_restart",   16'(an_restart_config), 16'h0);
        check("rst_irq",       16'(link_change_irq), 16'h0);
        check("rst_down_cnt",  16'(link_down_count), 16'h0);
        check("rst_err_cnt",   16'(rx_error_count), 16'h0);
        check("rst_state",     16'(link_state), 16'(DOWN));

        // Timeout restart: link held low from reset, RESTART spans edges 100..104
        reset = 1'b1;
        tick(99);
        check("to_before",     16'(an_restart_config), 16'h0);
        tick(1);
        check("to_rise",       16'(an_restart_config), 16'h1);
        tick(3);
        check("to_hold",       16'(an_restart_config), 16'h1);
        tick(1);
        check("to_fall",       16'(an_restart_config), 16'h0);
        check("to_state_down", 16'(link_state), 16'(DOWN));
        tick(99);
        check("to2_before",    16'(an_restart_config), 16'h0);
        tick(1);
        check("to2_rise",      16'(an_restart_config), 16'h1);
        tick(1);
        check("to2_state",     16'(link_state), 16'(RESTART));

        // Asynchronous reset in RESTART drops the request without a clock edge
        #1 reset = 1'b0;
        #1;
        check("async_restart", 16'(an_restart_config), 16'h0);
        check("async_state",   16'(link_state), 16'(DOWN));
        tick(1);
        reset = 1'b1;

        // Clean link-up at 1 Gb/s, full duplex
        status_vector = 16'h1883;
        tick(8);
        check("up_edge8",    16'(link_up), 16'h0);
        tick(1);
        check("up_edge9",    16'(link_up), 16'h1);
        check("up_speed",    16'(speed), 16'h2);
        check("up_duplex",   16'(full_duplex), 16'h1);
        check("up_irq",      16'(link_change_irq), 16'h1);
        check("up_state",    16'(link_state), 16'(UP));
        pulse_ack();
        check("ack_clears",  16'(link_change_irq), 16'h0);

        // Speed change 1000 -> 100 while UP
        status_vector = 16'h1483;
        tick(1);
        check("spd_edge1",      16'(link_up), 16'h1);
        tick(1);
        check("spd_edge2",      16'(link_up), 16'h0);
        check("spd_down_cnt",   16'(link_down_count), 16'h1);
        check("spd_irq",        16'(link_change_irq), 16'h1);
        tick(6);
        check("spd_edge8",      16'(link_up), 16'h0);
        tick(1);
        check("spd_edge9",      16'(link_up), 16'h1);
        check("spd_speed",      16'(speed), 16'h1);
        check("spd_is100_lag",  16'(speed_is_100), 16'h0);
        tick(1);
        check("spd_is100",      16'(speed_is_100), 16'h1);
        check("spd_is10_100",   16'(speed_is_10_100), 16'h1);
        pulse_ack();

        // Link loss, then a 5-cycle glitch that must be rejected
        status_vector = 16'h0000;
        tick(2);
        check("drop_link_up",   16'(link_up), 16'h0);
        check("drop_down_cnt",  16'(link_down_count), 16'h2);
        pulse_ack();
        check("drop_ack",       16'(link_change_irq), 16'h0);
        status_vector = 16'h1483;
        tick(5);
        status_vector = 16'h0000;
        tick(10);
        check("glitch_link_up", 16'(link_up), 16'h0);
        check("glitch_irq",     16'(link_change_irq), 16'h0);
        check("glitch_state",   16'(link_state), 16'(DOWN));
        status_vector = 16'h1483;
        tick(8);
        check("relock_edge8",   16'(link_up), 16'h0);
        tick(1);
        check("relock_edge9",   16'(link_up), 16'h1);
        check("relock_irq",     16'(link_change_irq), 16'h1);

        // Interrupt: set and ack in the same cycle, set wins
        pulse_ack();
        check("pri_pre",   16'(link_change_irq), 16'h0);
        an_interrupt = 1'b1;
        tick(1);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        check("pri_set_wins", 16'(link_change_irq), 16'h1);
        an_interrupt = 1'b0;
        pulse_ack();
        tick(3);
        check("an_fall_no_irq", 16'(link_change_irq), 16'h0);

        // Error counter: rxdisperr held, saturates at F, clear beats increment
        status_vector = 16'h14A3;
        tick(1);
        check("err_edge1",  16'(rx_error_count), 16'h0);
        tick(1);
        check("err_edge2",  16'(rx_error_count), 16'h1);
        tick(13);
        check("err_edge15", 16'(rx_error_count), 16'hE);
        tick(1);
        check("err_edge16", 16'(rx_error_count), 16'hF);
        tick(4);
        check("err_sat",    16'(rx_error_count), 16'hF);
        check("err_link",   16'(link_up), 16'h1);
        check("pre_clr_down_cnt", 16'(link_down_count), 16'h2);
        counters_clear = 1'b1;
        tick(1);
        counters_clear = 1'b0;
        check("clr_err_cnt",  16'(rx_error_count), 16'h0);
        check("clr_down_cnt", 16'(link_down_count), 16'h0);
        tick(1);
        check("post_clr_inc", 16'(rx_error_count), 16'h1);
        status_vector = 16'h1483;
        tick(3);
        check("err_stop",     16'(rx_error_count), 16'h2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
